// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Holds the clear FSM states, default geometry and the zero-register address.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ADDR_BITS = 5;
  localparam int ZERO_ADDR     = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports, writeback, reserve and bulk clear.
// master = issue/writeback side, slave = register file.
interface regfile_sb_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
);

  logic [ADDR_BITS-1:0] ReadRegister1;
  logic [ADDR_BITS-1:0] ReadRegister2;
  logic [WIDTH-1:0]     ReadData1;
  logic [WIDTH-1:0]     ReadData2;
  logic                 ReadReady1;
  logic                 ReadReady2;
  logic [ADDR_BITS-1:0] WriteRegister;
  logic [WIDTH-1:0]     WriteData;
  logic                 RegWrite;
  logic [ADDR_BITS-1:0] ReserveRegister;
  logic                 Reserve;
  logic                 Clear;
  logic                 Busy;
  logic [ADDR_BITS:0]   PendingCount;

  modport master (
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2,
    input  ReadReady1,
    input  ReadReady2,
    output WriteRegister,
    output WriteData,
    output RegWrite,
    output ReserveRegister,
    output Reserve,
    output Clear,
    input  Busy,
    input  PendingCount
  );

  modport slave (
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2,
    output ReadReady1,
    output ReadReady2,
    input  WriteRegister,
    input  WriteData,
    input  RegWrite,
    input  ReserveRegister,
    input  Reserve,
    input  Clear,
    output Busy,
    output PendingCount
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-bit scoreboard: one bit per register plus a running popcount.
// Ports: clk/rst, write/reserve/clear strobes, two lookups, count.
module regfile_sb_scoreboard #(
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wrEn,
  input  logic [ADDR_BITS-1:0] wrAddr,
  input  logic                 rsvEn,
  input  logic [ADDR_BITS-1:0] rsvAddr,
  input  logic                 clrEn,
  input  logic [ADDR_BITS-1:0] clrAddr,
  input  logic [ADDR_BITS-1:0] rdAddr1,
  input  logic [ADDR_BITS-1:0] rdAddr2,
  output logic                 pend1,
  output logic                 pend2,
  output logic [ADDR_BITS:0]   count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] One = 1;

  logic [DEPTH-1:0]   pending;
  logic [DEPTH-1:0]   pendingNext;
  logic [ADDR_BITS:0] countNext;
  logic               inc;
  logic               dec;

  always_comb begin
    pendingNext = pending;
    if (clrEn) pendingNext[clrAddr] = 1'b0;
    if (wrEn)  pendingNext[wrAddr]  = 1'b0;
    // reserve last: a new producer beats a same-cycle writeback
    if (rsvEn) pendingNext[rsvAddr] = 1'b1;
  end

  always_comb begin
    inc = rsvEn && !pending[rsvAddr];
    dec = (wrEn && pending[wrAddr] &&
           !(rsvEn && rsvAddr == wrAddr))
       || (clrEn && pending[clrAddr]);
    countNext = count;
    if (inc && !dec)      countNext = count + One;
    else if (dec && !inc) countNext = count - One;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pendingNext;
      count   <= countNext;
    end
  end

  assign pend1 = pending[rdAddr1];
  assign pend2 = pending[rdAddr2];

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending scoreboard, write bypass and bulk clear.
// Ports: Clk, Reset_n (async low), bus (regfile_sb_if.slave).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input logic        Clk,
  input logic        Reset_n,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam bit ZeroEn = (ZERO_REG != 0);
  localparam bit BypEn  = (BYPASS != 0);
  localparam logic [ADDR_BITS-1:0] ZeroA = ADDR_BITS'(ZERO_ADDR);
  localparam logic [ADDR_BITS-1:0] LastA = ADDR_BITS'(DEPTH - 1);

  state_e               state;
  state_e               stateNext;
  logic [ADDR_BITS-1:0] cnt;
  logic [ADDR_BITS-1:0] cntNext;
  logic                 clrEn;
  logic                 busy;
  logic                 wrEn;
  logic                 rsvEn;
  logic                 pend1;
  logic                 pend2;
  logic                 zero1;
  logic                 zero2;
  logic                 byp1;
  logic                 byp2;
  logic [ADDR_BITS:0]   count;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    clrEn     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.Clear) stateNext = CLEAR;
      end
      CLEAR: begin
        clrEn   = 1'b1;
        cntNext = cnt + 1'b1;
        if (cnt == LastA) begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state == CLEAR);

  // a Clear pulse swallows that cycle's write and reserve
  assign wrEn = !busy && !bus.Clear && bus.RegWrite
             && !(ZeroEn && bus.WriteRegister == ZeroA);
  assign rsvEn = !busy && !bus.Clear && bus.Reserve
              && !(ZeroEn && bus.ReserveRegister == ZeroA);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clrEn) begin
      mem[cnt] <= '0;
    end else if (wrEn) begin
      mem[bus.WriteRegister] <= bus.WriteData;
    end
  end

  regfile_sb_scoreboard #(
    .ADDR_BITS(ADDR_BITS)
  ) u_sb (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .wrEn   (wrEn),
    .wrAddr (bus.WriteRegister),
    .rsvEn  (rsvEn),
    .rsvAddr(bus.ReserveRegister),
    .clrEn  (clrEn),
    .clrAddr(cnt),
    .rdAddr1(bus.ReadRegister1),
    .rdAddr2(bus.ReadRegister2),
    .pend1  (pend1),
    .pend2  (pend2),
    .count  (count)
  );

  assign zero1 = ZeroEn && bus.ReadRegister1 == ZeroA;
  assign zero2 = ZeroEn && bus.ReadRegister2 == ZeroA;

  assign byp1 = BypEn && !busy && bus.RegWrite && !zero1
             && bus.WriteRegister == bus.ReadRegister1;
  assign byp2 = BypEn && !busy && bus.RegWrite && !zero2
             && bus.WriteRegister == bus.ReadRegister2;

  always_comb begin
    bus.ReadData1 = mem[bus.ReadRegister1];
    if (zero1)     bus.ReadData1 = '0;
    else if (byp1) bus.ReadData1 = bus.WriteData;
  end

  always_comb begin
    bus.ReadData2 = mem[bus.ReadRegister2];
    if (zero2)     bus.ReadData2 = '0;
    else if (byp2) bus.ReadData2 = bus.WriteData;
  end

  assign bus.ReadReady1 = !busy && (zero1 || byp1 || !pend1);
  assign bus.ReadReady2 = !busy && (zero2 || byp2 || !pend2);

  assign bus.Busy         = busy;
  assign bus.PendingCount = count;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed plan plus random traffic.
// Two builds: 32x32 with zero reg, 8x16 without.
module tb_regfile_sb;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  regfile_sb_if #(.WIDTH(32), .ADDR_BITS(5)) bus ();
  regfile_sb_if #(.WIDTH(16), .ADDR_BITS(3)) bus16 ();

  regfile_sb #(
    .WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  regfile_sb #(
    .WIDTH(16), .ADDR_BITS(3), .ZERO_REG(0), .BYPASS(1)
  ) dut16 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus16)
  );

  int nChecks = 0;
  int nFails = 0;

  logic [31:0] mMem [32];
  bit          mPend [32];
  bit          mBusy;
  int          mIdx;

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mMem[i] = '0;
      mPend[i] = 1'b0;
    end
    mBusy = 1'b0;
    mIdx = 0;
  endtask

  function automatic logic [31:0] expData(logic [4:0] a);
    if (a == 0) return '0;
    if (!mBusy && bus.RegWrite && bus.WriteRegister == a)
      return bus.WriteData;
    return mMem[a];
  endfunction

  function automatic logic expReady(logic [4:0] a);
    if (mBusy) return 1'b0;
    if (a == 0) return 1'b1;
    if (bus.RegWrite && bus.WriteRegister == a) return 1'b1;
    return !mPend[a];
  endfunction

  function automatic int popCount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mPend[i]);
    return n;
  endfunction

  task automatic checkAll();
    check("rd1", bus.ReadData1, expData(bus.ReadRegister1));
    check("rd2", bus.ReadData2, expData(bus.ReadRegister2));
    check("rdy1", bus.ReadReady1, expReady(bus.ReadRegister1));
    check("rdy2", bus.ReadReady2, expReady(bus.ReadRegister2));
    check("busy", bus.Busy, mBusy);
    check("pcount", bus.PendingCount, popCount());
  endtask

  task automatic modelClock();
    if (mBusy) begin
      mMem[mIdx] = '0;
      mPend[mIdx] = 1'b0;
      mIdx++;
      if (mIdx == 32) begin
        mBusy = 1'b0;
        mIdx = 0;
      end
    end else if (bus.Clear) begin
      mBusy = 1'b1;
      mIdx = 0;
    end else begin
      if (bus.RegWrite && bus.WriteRegister != 0) begin
        mMem[bus.WriteRegister] = bus.WriteData;
        mPend[bus.WriteRegister] = 1'b0;
      end
      if (bus.Reserve && bus.ReserveRegister != 0)
        mPend[bus.ReserveRegister] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    checkAll();
    @(posedge Clk);
    modelClock();
    #1;
  endtask

  task automatic idleIn();
    bus.RegWrite = 1'b0;
    bus.Reserve = 1'b0;
    bus.Clear = 1'b0;
    bus.WriteRegister = '0;
    bus.WriteData = '0;
    bus.ReserveRegister = '0;
  endtask

  initial begin
    int bc;
    idleIn();
    bus.ReadRegister1 = 5'd5;
    bus.ReadRegister2 = 5'd0;
    bus16.ReadRegister1 = '0;
    bus16.ReadRegister2 = '0;
    bus16.WriteRegister = '0;
    bus16.WriteData = '0;
    bus16.RegWrite = 1'b0;
    bus16.ReserveRegister = '0;
    bus16.Reserve = 1'b0;
    bus16.Clear = 1'b0;
    modelReset();
    #12;
    check("rst busy", bus.Busy, 1'b0);
    check("rst pcount", bus.PendingCount, 0);
    check("rst rd1", bus.ReadData1, 0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // 1: plain write then read on both ports
    bus.WriteRegister = 5'd5;
    bus.WriteData = 32'hDEADBEEF;
    bus.RegWrite = 1'b1;
    tick();
    idleIn();
    bus.ReadRegister1 = 5'd5;
    bus.ReadRegister2 = 5'd5;
    #3;
    check("t1 rd1", bus.ReadData1, 32'hDEADBEEF);
    check("t1 rd2", bus.ReadData2, 32'hDEADBEEF);
    check("t1 rdy1", bus.ReadReady1, 1'b1);
    tick();

    // 2: reserve, then bypassed writeback
    bus.Reserve = 1'b1;
    bus.ReserveRegister = 5'd7;
    tick();
    idleIn();
    bus.ReadRegister1 = 5'd7;
    #3;
    check("t2 rdy1 pend", bus.ReadReady1, 1'b0);
    check("t2 pcount1", bus.PendingCount, 1);
    tick();
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd7;
    bus.WriteData = 32'h12;
    #3;
    check("t2 byp data", bus.ReadData1, 32'h12);
    check("t2 byp rdy", bus.ReadReady1, 1'b1);
    tick();
    idleIn();
    #3;
    check("t2 pcount0", bus.PendingCount, 0);
    tick();

    // 3: register 0 ignores writes and reserves
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd0;
    bus.WriteData = 32'hFFFFFFFF;
    bus.Reserve = 1'b1;
    bus.ReserveRegister = 5'd0;
    bus.ReadRegister1 = 5'd0;
    tick();
    idleIn();
    #3;
    check("t3 rd0", bus.ReadData1, 0);
    check("t3 rdy0", bus.ReadReady1, 1'b1);
    check("t3 pcount", bus.PendingCount, 0);
    tick();

    // 4: reserve and write same register together
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd3;
    bus.WriteData = 32'h55;
    bus.Reserve = 1'b1;
    bus.ReserveRegister = 5'd3;
    tick();
    idleIn();
    bus.ReadRegister1 = 5'd3;
    #3;
    check("t4 data", bus.ReadData1, 32'h55);
    check("t4 rdy", bus.ReadReady1, 1'b0);
    check("t4 pcount", bus.PendingCount, 1);
    tick();

    // 5: fill, reserve, bulk clear with a write during Busy
    for (int i = 1; i < 32; i++) begin
      bus.RegWrite = 1'b1;
      bus.WriteRegister = 5'(i);
      bus.WriteData = 32'h1000_0000 | i;
      tick();
    end
    idleIn();
    bus.Reserve = 1'b1;
    bus.ReserveRegister = 5'd4;
    tick();
    idleIn();
    bus.Clear = 1'b1;
    tick();
    idleIn();
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      bus.RegWrite = 1'b1;
      bus.WriteRegister = 5'd9;
      bus.WriteData = 32'hBAD;
      #1;
      if (bus.Busy) bc++;
      else break;
      tick();
    end
    idleIn();
    check("t5 busy cycles", bc, 32);
    for (int a = 0; a < 32; a++) begin
      bus.ReadRegister1 = 5'(a);
      bus.ReadRegister2 = 5'(31 - a);
      #1;
      check("t5 rd1 zero", bus.ReadData1, 0);
      check("t5 rdy1", bus.ReadReady1, 1'b1);
      tick();
    end
    check("t5 pcount", bus.PendingCount, 0);

    // 6: reset in the middle of a clear
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd6;
    bus.WriteData = 32'h66;
    tick();
    idleIn();
    bus.Clear = 1'b1;
    tick();
    idleIn();
    repeat (10) tick();
    Reset_n = 1'b0;
    modelReset();
    bus.ReadRegister1 = 5'd6;
    #1;
    check("t6 busy", bus.Busy, 1'b0);
    check("t6 rd", bus.ReadData1, 0);
    check("t6 pcount", bus.PendingCount, 0);
    Reset_n = 1'b1;
    tick();
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd6;
    bus.WriteData = 32'h77;
    tick();
    idleIn();
    #1;
    check("t6 post wr", bus.ReadData1, 32'h77);
    tick();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.ReadRegister1 = 5'($urandom_range(0, 31));
      bus.ReadRegister2 = 5'($urandom_range(0, 31));
      bus.WriteRegister = 5'($urandom_range(0, 31));
      bus.WriteData = $urandom;
      bus.RegWrite = 1'($urandom_range(0, 1));
      bus.ReserveRegister = 5'($urandom_range(0, 31));
      bus.Reserve = 1'($urandom_range(0, 1));
      bus.Clear = ($urandom_range(0, 99) == 0);
      tick();
    end
    idleIn();

    // 7: 8x16 build without a zero register
    bus16.WriteRegister = 3'd0;
    bus16.WriteData = 16'hABCD;
    bus16.RegWrite = 1'b1;
    @(posedge Clk);
    #1;
    bus16.RegWrite = 1'b0;
    bus16.ReadRegister1 = 3'd0;
    #1;
    check("t7 r0 data", bus16.ReadData1, 16'hABCD);
    check("t7 r0 rdy", bus16.ReadReady1, 1'b1);
    bus16.Clear = 1'b1;
    @(posedge Clk);
    #1;
    bus16.Clear = 1'b0;
    bc = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus16.Busy) bc++;
      else break;
      @(posedge Clk);
      #1;
    end
    check("t7 busy cycles", bc, 8);
    check("t7 r0 cleared", bus16.ReadData1, 0);
    check("t7 pcount", bus16.PendingCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
